keyed_stream_decoder: RTL and testbench

- Receiver end of the team's keyed-gate scheme. The sender transmits each data bit XOR a key bit, which is the same "key=0 pass / key=1 invert" operation as the keyed AND/NAND gate.
- This block regenerates the identical key stream from a shared seed, strips the key from each received serial bit, and deserialises the result into words.
- Completed words are presented on a valid/ready output port to downstream logic.

---
 rtl/keyed_pkg.sv | 32 +++
 rtl/keyed_lfsr.sv | 42 ++++
 rtl/keyed_stream_decoder.sv | 170 +++++++++++++++++
 tb/tb_keyed_stream_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_pkg.sv
// ---------------------------------------------------------------------------
// keyed_pkg
// Shared definitions for the keyed-gate scheme (decoder now, transmitter later).
// The sender XORs each data bit with a key bit from an 8-bit Galois LFSR.
// The receiver must regenerate the identical key stream, so the LFSR math
// lives here and both ends call lfsr_next().
//
// Contents:
//   LFSR_W        - LFSR width (8)
//   LFSR_TAPS     - Galois tap mask for right-shift form (8'hB8)
//   LFSR_ZERO_FIX - substitute seed used when a zero seed is loaded (8'h01)
//   dec_state_t   - decoder FSM states {IDLE, RUN}
//   lfsr_next()   - one LFSR step
// ---------------------------------------------------------------------------
package keyed_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_FIX = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    // Right-shifting Galois step: the bit falling out of position 0 is the
    // key bit, and when it is 1 the taps are folded back into the register.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
    endfunction

endpackage

// File: rtl/keyed_lfsr.sv
// ---------------------------------------------------------------------------
// keyed_lfsr
// Key-stream generator for the keyed-gate scheme. Holds the LFSR state,
// loads a seed (zero seeds are replaced so the register never locks up),
// and advances one step per consumed key bit.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (state -> LFSR_ZERO_FIX)
//   seed     in   LFSR_W-bit seed value
//   load     in   load seed this cycle (has priority over advance)
//   advance  in   step the LFSR this cycle
//   key      out  current key bit (lfsr[0])
// ---------------------------------------------------------------------------
module keyed_lfsr
    import keyed_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic              key
);

    logic [LFSR_W-1:0] lfsr_q;

    // LFSR state register. The all-zero state is a fixed point of the
    // Galois LFSR, so a zero seed is mapped to LFSR_ZERO_FIX on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_ZERO_FIX;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? LFSR_ZERO_FIX : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign key = lfsr_q[0];

endmodule

// File: rtl/keyed_stream_decoder.sv
// ---------------------------------------------------------------------------
// keyed_stream_decoder
// Receiver for the keyed-gate scheme. Regenerates the key stream from a
// shared seed, strips the key from each received serial bit, deserialises
// the decoded bits LSB-first into DATA_W-bit words and presents each word on
// a valid/ready port.
//
// Parameters:
//   DATA_W  bits per output word (2..32)
//   SEED_W  seed width; must equal keyed_pkg::LFSR_W (8)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   seed_i      in   key seed
//   seed_ld_i   in   load seed; starts/restarts a session, drops partial word
//   bit_i       in   keyed serial data bit
//   bit_vld_i   in   bit_i valid (no backpressure)
//   data_o      out  decoded word
//   data_vld_o  out  data_o valid
//   data_rdy_i  in   consumer accepts data_o
//   busy_o      out  FSM is in RUN
//   ovf_o       out  sticky overflow (word completed while output stalled)
//   par_err_o   out  parity error for current data_o
//
// Optional feature macro: KEYED_DEC_PARITY_EN
//   Defined   - each word is followed by one keyed even-parity bit; the word
//               is registered when that bit arrives and par_err_o reports a
//               mismatch, held together with data_o.
//   Undefined - no parity bit, par_err_o is constant 0.
// ---------------------------------------------------------------------------
module keyed_stream_decoder
    import keyed_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEED_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              seed_ld_i,
    input  logic              bit_i,
    input  logic              bit_vld_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_vld_o,
    input  logic              data_rdy_i,
    output logic              busy_o,
    output logic              ovf_o,
    output logic              par_err_o
);

    // With parity enabled the shift register keeps all DATA_W data bits while
    // the parity bit arrives; without it, the final data bit goes straight
    // from bit_i into the word, so one fewer stored bit is needed.
`ifdef KEYED_DEC_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int SHR_W = FRAME_W - 1;
    localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    dec_state_t state_q, state_d;

    logic               key;
    logic               dec_bit;
    logic               accept;
    logic               word_done;
    logic               stalled;
    logic               load_word;
    logic [CNT_W-1:0]   cnt_q;
    logic [SHR_W-1:0]   shreg_q;
    logic [SHR_W:0]     shift_in;

    keyed_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (seed_i),
        .load    (seed_ld_i),
        .advance (accept),
        .key     (key)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a seed load always lands in RUN; RUN is only left by reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (seed_ld_i) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN);

    // A seed load in the same cycle as a valid bit wins; the bit is dropped.
    assign accept    = busy_o && bit_vld_i && !seed_ld_i;
    assign dec_bit   = bit_i ^ key;
    assign shift_in  = {dec_bit, shreg_q};
    assign word_done = accept && (cnt_q == LAST_IDX);
    assign stalled   = data_vld_o && !data_rdy_i;
    assign load_word = word_done && !stalled;

    // Bit counter and deserialiser. New bits enter at the top and move down,
    // so the first bit of a frame ends up at word bit 0. Stale bits need no
    // clearing at a word boundary; the next frame overwrites all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (seed_ld_i) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (accept) begin
            shreg_q <= shift_in[SHR_W:1];
            cnt_q   <= word_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Output word register and valid flag. A completed word is dropped when
    // the current one is still waiting; a transfer coinciding with a new word
    // keeps valid high and replaces the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o     <= '0;
            data_vld_o <= 1'b0;
        end else if (load_word) begin
            data_o     <= shift_in[DATA_W-1:0];
            data_vld_o <= 1'b1;
        end else if (data_vld_o && data_rdy_i) begin
            data_vld_o <= 1'b0;
        end
    end

    // Sticky overflow: set on a dropped word, cleared only by a new session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else if (seed_ld_i) begin
            ovf_o <= 1'b0;
        end else if (word_done && stalled) begin
            ovf_o <= 1'b1;
        end
    end

`ifdef KEYED_DEC_PARITY_EN
    // Parity flag travels with data_o: the received parity bit sits above the
    // data bits in shift_in, and even parity means the XOR of all is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_o <= 1'b0;
        end else if (load_word) begin
            par_err_o <= ^shift_in[DATA_W:0];
        end
    end
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_keyed_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_keyed_stream_decoder
// Self-checking bench for keyed_stream_decoder. A transaction-level model
// keeps the key LFSR as an integer, collects decoded bits in a queue and
// forms words once a frame is complete; output handshake state is tracked
// from the valid/ready rules. Directed steps cover reset, the known-answer
// word 8'h71, zero-seed fix, re-seed, overflow and parity, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_keyed_stream_decoder;

    localparam int DW = 8;
`ifdef KEYED_DEC_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    seed_i;
    logic          seed_ld_i;
    logic          bit_i;
    logic          bit_vld_i;
    logic [DW-1:0] data_o;
    logic          data_vld_o;
    logic          data_rdy_i;
    logic          busy_o;
    logic          ovf_o;
    logic          par_err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            m_lfsr;
    bit            m_bits[$];
    bit            m_run;
    logic [DW-1:0] m_data;
    logic          m_vld;
    logic          m_ovf;
    logic          m_perr;

    keyed_stream_decoder #(.DATA_W(DW), .SEED_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_i     (seed_i),
        .seed_ld_i  (seed_ld_i),
        .bit_i      (bit_i),
        .bit_vld_i  (bit_vld_i),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .data_rdy_i (data_rdy_i),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o),
        .par_err_o  (par_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model reset: everything back to power-on values.
    task automatic resetModel();
        m_lfsr = 1;
        m_bits.delete();
        m_run  = 1'b0;
        m_data = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    // One clock of the model, evaluated from the inputs and current outputs.
    task automatic modelStep(input bit ld, input int seed, input bit vld,
                             input bit b, input bit rdy);
        bit            done = 1'b0;
        logic [DW-1:0] word = '0;
        bit            perr = 1'b0;
        if (ld) begin
            m_lfsr = (seed == 0) ? 1 : seed;
            m_bits.delete();
            m_ovf  = 1'b0;
            m_run  = 1'b1;
        end else if (m_run && vld) begin
            m_bits.push_back(b ^ bit'(m_lfsr % 2));
            m_lfsr = (m_lfsr / 2) ^ (((m_lfsr % 2) == 1) ? 184 : 0);
            if (m_bits.size() == FRAME) begin
                int ones = 0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i < DW) word[i] = m_bits[i];
                    ones += int'(m_bits[i]);
                end
`ifdef KEYED_DEC_PARITY_EN
                perr = (ones % 2) != 0;
`endif
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (m_vld && !rdy) begin
                m_ovf = 1'b1;
            end else begin
                m_data = word;
                m_vld  = 1'b1;
                m_perr = perr;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (data_o === m_data) else begin
            errors++;
            $error("[TB] FAIL %s data_o observed=%h expected=%h", tag, data_o, m_data);
        end
        checks++;
        assert (data_vld_o === m_vld) else begin
            errors++;
            $error("[TB] FAIL %s data_vld_o observed=%b expected=%b", tag, data_vld_o, m_vld);
        end
        checks++;
        assert (busy_o === m_run) else begin
            errors++;
            $error("[TB] FAIL %s busy_o observed=%b expected=%b", tag, busy_o, m_run);
        end
        checks++;
        assert (ovf_o === m_ovf) else begin
            errors++;
            $error("[TB] FAIL %s ovf_o observed=%b expected=%b", tag, ovf_o, m_ovf);
        end
        checks++;
        assert (par_err_o === m_perr) else begin
            errors++;
            $error("[TB] FAIL %s par_err_o observed=%b expected=%b", tag, par_err_o, m_perr);
        end
    endtask

    // Known-answer check against a constant taken from hand calculation.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input string tag, input bit ld, input int seed,
                                 input bit vld, input bit b, input bit rdy);
        seed_ld_i  = ld;
        seed_i     = 8'(seed);
        bit_vld_i  = vld;
        bit_i      = b;
        data_rdy_i = rdy;
        modelStep(ld, seed, vld, b, rdy);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Send n raw (keyed) bits LSB-first from raw on consecutive cycles.
    task automatic sendBits(input string tag, input logic [31:0] raw,
                            input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b0, 0, 1'b1, raw[i], rdy);
        end
    endtask

    task automatic idleCycle(input string tag, input bit rdy);
        applyStimulus(tag, 1'b0, 0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        rst_n      = 1'b0;
        seed_i     = '0;
        seed_ld_i  = 1'b0;
        bit_i      = 1'b0;
        bit_vld_i  = 1'b0;
        data_rdy_i = 1'b0;
        resetModel();
        $display("[TB] start, FRAME=%0d", FRAME);

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        // IDLE ignores bits.
        for (int i = 0; i < 4; i++) applyStimulus("idle_bits", 1'b0, 0, 1'b1, 1'b1, 1'b1);

        // Seed 01, all-zero raw bits: decoded word is the key stream itself.
        applyStimulus("seed01", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        sendBits("kat_pre", 32'h0, DW - 1, 1'b1);
        checkValue("kat_not_yet_valid", {31'd0, data_vld_o}, 32'd0);
        sendBits("kat_last", 32'h0, FRAME - DW + 1, 1'b1);
        checkValue("kat_valid", {31'd0, data_vld_o}, 32'd1);
        checkValue("kat_word", 32'(data_o), 32'h71);
        idleCycle("kat_drain", 1'b1);

        // Zero seed behaves as seed 01; sending the key stream decodes to 0.
        applyStimulus("seed00", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        sendBits("zero_fix", 32'h71, FRAME, 1'b1);
        checkValue("zero_fix_word", 32'(data_o), 32'h00);
        checkValue("zero_fix_valid", {31'd0, data_vld_o}, 32'd1);
        idleCycle("zero_fix_drain", 1'b1);

        // Re-seed mid-word discards the partial bits.
        applyStimulus("reseed_a", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        sendBits("reseed_partial", 32'h0, 3, 1'b1);
        applyStimulus("reseed_b", 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        sendBits("reseed_word", 32'h0, FRAME, 1'b1);
        checkValue("reseed_word_val", 32'(data_o), 32'h71);
        idleCycle("reseed_drain", 1'b1);

        // Backpressure: second word is dropped and ovf_o set.
        applyStimulus("bp_seed", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        sendBits("bp_w1", 32'h0, FRAME, 1'b0);
        sendBits("bp_w2", 32'h0, FRAME, 1'b0);
        checkValue("bp_hold_word", 32'(data_o), 32'h71);
        checkValue("bp_ovf", {31'd0, ovf_o}, 32'd1);
        applyStimulus("bp_clear", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        checkValue("bp_ovf_cleared", {31'd0, ovf_o}, 32'd0);
        idleCycle("bp_drain", 1'b1);

`ifdef KEYED_DEC_PARITY_EN
        // Correct parity bit (decoded 0), then flipped.
        applyStimulus("par_seed", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        sendBits("par_ok", 32'h0, FRAME, 1'b1);
        checkValue("par_ok_word", 32'(data_o), 32'h71);
        checkValue("par_ok_flag", {31'd0, par_err_o}, 32'd0);
        applyStimulus("par_seed2", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        sendBits("par_bad", 32'h100, FRAME, 1'b1);
        checkValue("par_bad_word", 32'(data_o), 32'h71);
        checkValue("par_bad_flag", {31'd0, par_err_o}, 32'd1);
        idleCycle("par_drain", 1'b1);
`endif

        // Async reset in the middle of a stream with a word pending.
        applyStimulus("ar_seed", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        sendBits("ar_word", 32'h5C, FRAME, 1'b0);
        sendBits("ar_part", 32'h3, 2, 1'b0);
        rst_n = 1'b0;
        resetModel();
        #2;
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("ar_ignored", 1'b0, 0, 1'b1, 1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit ld  = ($urandom_range(0, 39) == 0) || (i == 0);
            int sd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            bit vld = $urandom_range(0, 3) != 0;
            bit b   = 1'($urandom);
            bit rdy = $urandom_range(0, 4) > 1;
            applyStimulus("random", ld, sd, vld, b, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
